// File: rtl/hs_sync_rx_if.sv
// rtl/hs_sync_rx_if.sv - 4-phase REQ/ACK receive bus: source request/data/ack plus consumer valid/ready
interface hs_sync_rx_if #(
    parameter int BUS_WIDTH = 8
);
    logic                 ASYNC_REQ;
    logic [BUS_WIDTH-1:0] ASYNC_DATA;
    logic                 ASYNC_PAR;
    logic                 ACK;
    logic [BUS_WIDTH-1:0] DOUT;
    logic                 DOUT_VALID;
    logic                 DOUT_READY;
    logic                 PAR_ERR;

    modport master (
        output ASYNC_REQ, ASYNC_DATA, ASYNC_PAR, DOUT_READY,
        input  ACK, DOUT, DOUT_VALID, PAR_ERR
    );

    modport slave (
        input  ASYNC_REQ, ASYNC_DATA, ASYNC_PAR, DOUT_READY,
        output ACK, DOUT, DOUT_VALID, PAR_ERR
    );
endinterface

// File: rtl/hs_sync_rx.sv
// rtl/hs_sync_rx.sv - 4-phase REQ/ACK CDC receiver with valid/ready output; HS_PARITY_EN adds parity drop
// Capture is gated until req_d holds a genuinely sampled REQ, so a REQ held high through reset is ignored.
module hs_sync_rx #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8
) (
    input  logic        CLK,
    input  logic        RST,
    hs_sync_rx_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t                 state, state_n;
    logic [NUM_STAGES-1:0]  sync;
    logic [NUM_STAGES:0]    primed;
    logic                   req_s, req_d, req_rise;
    logic                   ack_q, ack_n;
    logic                   valid_q, valid_n;
    logic [BUS_WIDTH-1:0]   dout_q, dout_n;

    assign req_s    = sync[NUM_STAGES-1];
    // primed[NUM_STAGES] marks that req_d came from a real post-reset sample
    assign req_rise = req_s & ~req_d & primed[NUM_STAGES];

`ifdef HS_PARITY_EN
    logic par_err_q, par_err_n;
    logic par_bad;
    assign par_bad     = ^bus.ASYNC_DATA ^ bus.ASYNC_PAR;
    assign bus.PAR_ERR = par_err_q;
`else
    assign bus.PAR_ERR = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync    <= '0;
            primed  <= '0;
            req_d   <= 1'b0;
            state   <= IDLE;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            dout_q  <= '0;
`ifdef HS_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            sync    <= {sync[NUM_STAGES-2:0], bus.ASYNC_REQ};
            primed  <= {primed[NUM_STAGES-1:0], 1'b1};
            req_d   <= req_s;
            state   <= state_n;
            ack_q   <= ack_n;
            valid_q <= valid_n;
            dout_q  <= dout_n;
`ifdef HS_PARITY_EN
            par_err_q <= par_err_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        ack_n   = ack_q;
        valid_n = valid_q;
        dout_n  = dout_q;
`ifdef HS_PARITY_EN
        par_err_n = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (req_rise) begin
`ifdef HS_PARITY_EN
                    if (par_bad) begin
                        par_err_n = 1'b1;
                        ack_n     = 1'b1;
                        state_n   = ACK;
                    end else
`endif
                    begin
                        dout_n  = bus.ASYNC_DATA;
                        valid_n = 1'b1;
                        state_n = VALID;
                    end
                end
            end
            VALID: begin
                if (bus.DOUT_READY) begin
                    valid_n = 1'b0;
                    ack_n   = 1'b1;
                    state_n = ACK;
                end
            end
            ACK: begin
                if (!req_s) begin
                    ack_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.ACK        = ack_q;
    assign bus.DOUT_VALID = valid_q;
    assign bus.DOUT       = dout_q;
endmodule

// File: tb/tb_hs_sync_rx.sv
// tb/tb_hs_sync_rx.sv - vector table plus corner sequences with a scoreboard for hs_sync_rx
module tb_hs_sync_rx;
    localparam int NS = 2;
    localparam int BW = 8;
`ifdef HS_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    hs_sync_rx_if #(.BUS_WIDTH(BW)) bus ();
    hs_sync_rx #(.NUM_STAGES(NS), .BUS_WIDTH(BW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    int checks = 0;
    int fails  = 0;
    int par_pulses = 0;
    int exp_par_pulses = 0;
    logic [BW-1:0] sb_q[$];
    logic [BW-1:0] last_good = '0;

    typedef struct {
        logic [BW-1:0] data;
        logic          par;
        int            hold;
        logic          bad;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (RST && bus.DOUT_VALID && bus.DOUT_READY) begin
            checks++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_unexpected: got word %0h expected none", bus.DOUT);
            end else begin
                logic [BW-1:0] e;
                e = sb_q.pop_front();
                if (bus.DOUT !== e) begin
                    fails++;
                    $display("FAIL scoreboard_dout: got %0h expected %0h", bus.DOUT, e);
                end
            end
        end
        if (bus.PAR_ERR) par_pulses++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_xfer(input logic [BW-1:0] data, input logic par, input int hold, input logic bad);
        int  cnt;
        bit  expect_word;
        expect_word = !(PAR_ON && bad);
        tick();
        bus.ASYNC_DATA = data;
        bus.ASYNC_PAR  = par;
        bus.DOUT_READY = (hold == 0);
        bus.ASYNC_REQ  = 1'b1;
        if (expect_word) sb_q.push_back(data);
        cnt = 0;
        while (!(bus.DOUT_VALID || bus.ACK) && cnt < 20) begin
            tick();
            cnt++;
        end
        check("capture_latency", cnt, NS + 1);
        if (expect_word) begin
            check("valid_after_capture", bus.DOUT_VALID, 1);
            check("dout_after_capture", bus.DOUT, data);
            check("par_err_good", bus.PAR_ERR, 0);
            for (int i = 0; i < hold; i++) begin
                tick();
                check("bp_valid_held", bus.DOUT_VALID, 1);
                check("bp_dout_held", bus.DOUT, data);
                check("bp_ack_low", bus.ACK, 0);
            end
            bus.DOUT_READY = 1'b1;
            tick();
            check("accept_valid_low", bus.DOUT_VALID, 0);
            check("accept_ack_high", bus.ACK, 1);
            last_good = data;
        end else begin
            exp_par_pulses++;
            check("par_err_pulse", bus.PAR_ERR, 1);
            check("par_bad_no_valid", bus.DOUT_VALID, 0);
            check("par_bad_ack", bus.ACK, 1);
            tick();
            check("par_err_one_cycle", bus.PAR_ERR, 0);
            check("par_bad_dout_kept", bus.DOUT, last_good);
        end
        bus.ASYNC_REQ = 1'b0;
        cnt = 0;
        while (bus.ACK && cnt < 20) begin
            tick();
            cnt++;
        end
        check("ack_fall_latency", cnt, NS + 1);
        repeat (2) tick();
        check("idle_valid_low", bus.DOUT_VALID, 0);
        check("dout_retained", bus.DOUT, last_good);
    endtask

    initial begin
        int cnt;
        vecs[0] = '{8'hA5, 1'b0, 0,  1'b0};
        vecs[1] = '{8'h3C, 1'b0, 10, 1'b0};
        vecs[2] = '{8'h01, 1'b0, 0,  1'b1};
        vecs[3] = '{8'h01, 1'b1, 0,  1'b0};
        vecs[4] = '{8'hFF, 1'b1, 2,  1'b1};
        vecs[5] = '{8'h80, 1'b1, 3,  1'b0};
        vecs[6] = '{8'h00, 1'b0, 1,  1'b0};

        bus.ASYNC_REQ  = 1'b0;
        bus.ASYNC_DATA = '0;
        bus.ASYNC_PAR  = 1'b0;
        bus.DOUT_READY = 1'b0;
        repeat (3) tick();
        check("reset_ack", bus.ACK, 0);
        check("reset_valid", bus.DOUT_VALID, 0);
        check("reset_dout", bus.DOUT, 0);
        check("reset_par_err", bus.PAR_ERR, 0);
        RST = 1'b1;
        repeat (5) tick();

        for (int i = 0; i < 7; i++)
            do_xfer(vecs[i].data, vecs[i].par, vecs[i].hold, vecs[i].bad);

        // early REQ fall while word is held by backpressure
        tick();
        bus.ASYNC_DATA = 8'h5A;
        bus.ASYNC_PAR  = 1'b0;
        bus.DOUT_READY = 1'b0;
        bus.ASYNC_REQ  = 1'b1;
        sb_q.push_back(8'h5A);
        cnt = 0;
        while (!bus.DOUT_VALID && cnt < 20) begin
            tick();
            cnt++;
        end
        check("early_capture_latency", cnt, NS + 1);
        bus.ASYNC_REQ = 1'b0;
        repeat (6) tick();
        check("early_valid_held", bus.DOUT_VALID, 1);
        check("early_dout_held", bus.DOUT, 8'h5A);
        check("early_ack_low", bus.ACK, 0);
        bus.DOUT_READY = 1'b1;
        tick();
        check("early_ack_high", bus.ACK, 1);
        tick();
        check("early_ack_one_cycle", bus.ACK, 0);
        repeat (4) tick();
        check("early_no_recapture", bus.DOUT_VALID, 0);
        last_good = 8'h5A;

        // REQ held high across reset release
        RST = 1'b0;
        bus.ASYNC_REQ = 1'b1;
        repeat (3) tick();
        RST = 1'b1;
        repeat (10) tick();
        check("rst_high_req_no_valid", bus.DOUT_VALID, 0);
        check("rst_high_req_no_ack", bus.ACK, 0);
        check("rst_high_req_dout", bus.DOUT, 0);
        bus.ASYNC_REQ = 1'b0;
        repeat (4) tick();
        last_good = '0;
        do_xfer(8'h69, 1'b0, 0, 1'b0);

        // reset asserted while in ACK
        tick();
        bus.ASYNC_DATA = 8'hC3;
        bus.ASYNC_PAR  = 1'b0;
        bus.DOUT_READY = 1'b1;
        bus.ASYNC_REQ  = 1'b1;
        sb_q.push_back(8'hC3);
        cnt = 0;
        while (!bus.ACK && cnt < 20) begin
            tick();
            cnt++;
        end
        check("midrst_reach_ack", bus.ACK, 1);
        RST = 1'b0;
        #2;
        check("midrst_ack", bus.ACK, 0);
        check("midrst_valid", bus.DOUT_VALID, 0);
        check("midrst_dout", bus.DOUT, 0);
        check("midrst_state_idle", 32'(dut.state), 0);
        repeat (2) tick();
        RST = 1'b1;
        repeat (8) tick();
        check("midrst_no_capture", bus.DOUT_VALID, 0);
        check("midrst_no_ack", bus.ACK, 0);
        bus.ASYNC_REQ = 1'b0;
        repeat (4) tick();
        last_good = '0;
        do_xfer(8'h96, 1'b0, 1, 1'b0);

        check("scoreboard_drained", sb_q.size(), 0);
        check("par_err_pulse_count", par_pulses, exp_par_pulses);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
